// File: rtl/instr_mem_loader_pkg.sv
// Instruction field layout, packed word type and loader state encoding for the RIDA core.
// Shared by the instruction-memory loader, its packer and future assembler benches.
package rida_isa_pkg;

   localparam int INSTR_W    = 32;
   localparam int COND_W     = 2;
   localparam int TIPO_W     = 2;
   localparam int OPCODE_W   = 3;
   localparam int RD_W       = 4;
   localparam int RN_W       = 4;
   localparam int MOVSH_W    = 2;
   localparam int MEMIDX_W   = 1;
   localparam int OP2_W      = 14;

   // Bit positions are derived from the LSB upward so the layout stays contiguous.
   localparam int OP2_LSB    = 0;
   localparam int OP2_MSB    = OP2_LSB + OP2_W - 1;
   localparam int MEMIDX_LSB = OP2_MSB + 1;
   localparam int MEMIDX_MSB = MEMIDX_LSB + MEMIDX_W - 1;
   localparam int MOVSH_LSB  = MEMIDX_MSB + 1;
   localparam int MOVSH_MSB  = MOVSH_LSB + MOVSH_W - 1;
   localparam int RN_LSB     = MOVSH_MSB + 1;
   localparam int RN_MSB     = RN_LSB + RN_W - 1;
   localparam int RD_LSB     = RN_MSB + 1;
   localparam int RD_MSB     = RD_LSB + RD_W - 1;
   localparam int OPCODE_LSB = RD_MSB + 1;
   localparam int OPCODE_MSB = OPCODE_LSB + OPCODE_W - 1;
   localparam int TIPO_LSB   = OPCODE_MSB + 1;
   localparam int TIPO_MSB   = TIPO_LSB + TIPO_W - 1;
   localparam int COND_LSB   = TIPO_MSB + 1;
   localparam int COND_MSB   = COND_LSB + COND_W - 1;

   typedef struct packed {
      logic [COND_W-1:0]   cond;
      logic [TIPO_W-1:0]   tipo;
      logic [OPCODE_W-1:0] opcode;
      logic [RD_W-1:0]     rd;
      logic [RN_W-1:0]     rn;
      logic [MOVSH_W-1:0]  mov_shift;
      logic [MEMIDX_W-1:0] mem_index;
      logic [OP2_W-1:0]    op2;
   } instr_t;

   typedef enum logic [2:0] {
      LS_IDLE  = 3'd0,
      LS_LOAD  = 3'd1,
      LS_DRAIN = 3'd2,
      LS_CHECK = 3'd3,
      LS_DONE  = 3'd4,
      LS_ERR   = 3'd5
   } loader_state_t;

endpackage

// File: rtl/instr_mem_loader_packer.sv
// instr_packer: combinational concatenation of instruction fields into the 32-bit Fetch/Decode word.
// No field is validated; every input bit lands in its slot unchanged.
module instr_packer
   import rida_isa_pkg::*;
(
   input  logic [COND_W-1:0]   i_cond,
   input  logic [TIPO_W-1:0]   i_tipo,
   input  logic [OPCODE_W-1:0] i_opcode,
   input  logic [RD_W-1:0]     i_rd,
   input  logic [RN_W-1:0]     i_rn,
   input  logic [MOVSH_W-1:0]  i_mov_shift,
   input  logic [MEMIDX_W-1:0] i_mem_index,
   input  logic [OP2_W-1:0]    i_op2,
   output instr_t              o_instr
);

   logic [INSTR_W-1:0] w_word;

   always_comb begin
      w_word                        = '0;
      w_word[COND_MSB:COND_LSB]     = i_cond;
      w_word[TIPO_MSB:TIPO_LSB]     = i_tipo;
      w_word[OPCODE_MSB:OPCODE_LSB] = i_opcode;
      w_word[RD_MSB:RD_LSB]         = i_rd;
      w_word[RN_MSB:RN_LSB]         = i_rn;
      w_word[MOVSH_MSB:MOVSH_LSB]   = i_mov_shift;
      w_word[MEMIDX_MSB:MEMIDX_LSB] = i_mem_index;
      w_word[OP2_MSB:OP2_LSB]       = i_op2;
   end

   assign o_instr = instr_t'(w_word);

endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: packs field bundles into instruction words and writes them to imem at 0,4,8,...
// Holds the core in reset until the load completes. Optional checksum via LOADER_CHECKSUM_EN.
module instr_mem_loader
   import rida_isa_pkg::*;
#(
   parameter int DEPTH    = 256,
   parameter int ADDR_W   = 8,
   parameter bit BOOT_RUN = 1'b0
)
(
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_start,
   input  logic                i_fld_valid,
   output logic                o_fld_ready,
   input  logic                i_fld_last,
   input  logic [COND_W-1:0]   i_fld_cond,
   input  logic [TIPO_W-1:0]   i_fld_tipo,
   input  logic [OPCODE_W-1:0] i_fld_opcode,
   input  logic [RD_W-1:0]     i_fld_rd,
   input  logic [RN_W-1:0]     i_fld_rn,
   input  logic [MOVSH_W-1:0]  i_fld_mov_shift,
   input  logic [MEMIDX_W-1:0] i_fld_mem_index,
   input  logic [OP2_W-1:0]    i_fld_op2,
   output logic                o_imem_we,
   output logic [31:0]         o_imem_waddr,
   output logic [31:0]         o_imem_wdata,
   output logic                o_cpu_run,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_err_overflow,
   output logic [ADDR_W:0]     o_word_count
`ifdef LOADER_CHECKSUM_EN
   ,
   input  logic                i_chk_valid,
   input  logic [31:0]         i_chk_value,
   output logic                o_err_chksum
`endif
);

   localparam int CNT_W = ADDR_W + 1;

   localparam logic [2:0] ST_IDLE  = LS_IDLE;
   localparam logic [2:0] ST_LOAD  = LS_LOAD;
   localparam logic [2:0] ST_DRAIN = LS_DRAIN;
   localparam logic [2:0] ST_CHECK = LS_CHECK;
   localparam logic [2:0] ST_DONE  = LS_DONE;
   localparam logic [2:0] ST_ERR   = LS_ERR;

   logic [2:0]       r_state;
   logic [2:0]       w_next_state;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_cnt_eff;
   logic             r_we;
   logic [31:0]      r_waddr;
   logic [31:0]      r_wdata;
   logic             r_cpu_run;
   logic             r_done;
   logic             r_err_overflow;
   logic             w_hs;
   logic             w_overflow;
   logic             w_write;
   logic             w_start_ok;
   instr_t           w_instr;

`ifdef LOADER_CHECKSUM_EN
   logic [31:0]      r_xor;
   logic             r_err_chksum;
   logic             w_chk_match;
`endif

   instr_packer u_packer (
      .i_cond      (i_fld_cond),
      .i_tipo      (i_fld_tipo),
      .i_opcode    (i_fld_opcode),
      .i_rd        (i_fld_rd),
      .i_rn        (i_fld_rn),
      .i_mov_shift (i_fld_mov_shift),
      .i_mem_index (i_fld_mem_index),
      .i_op2       (i_fld_op2),
      .o_instr     (w_instr)
   );

   // r_count lags the write by one cycle, so a word still in flight counts toward the next index.
   assign w_cnt_eff  = r_count + CNT_W'(r_we);
   assign w_hs       = i_fld_valid && (r_state == ST_LOAD);
   assign w_overflow = w_hs && (w_cnt_eff == CNT_W'(DEPTH));
   assign w_write    = w_hs && !w_overflow;
   assign w_start_ok = i_start &&
                       ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));

`ifdef LOADER_CHECKSUM_EN
   assign w_chk_match = (r_xor == i_chk_value);
`endif

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (i_start) begin
               w_next_state = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (w_overflow) begin
               w_next_state = ST_ERR;
            end else if (w_hs && i_fld_last) begin
               w_next_state = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
`ifdef LOADER_CHECKSUM_EN
            w_next_state = ST_CHECK;
`else
            w_next_state = ST_DONE;
`endif
         end
         ST_CHECK: begin
`ifdef LOADER_CHECKSUM_EN
            if (i_chk_valid) begin
               w_next_state = w_chk_match ? ST_DONE : ST_ERR;
            end
`else
            w_next_state = ST_IDLE;
`endif
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state        <= ST_IDLE;
         r_count        <= '0;
         r_we           <= 1'b0;
         r_waddr        <= '0;
         r_wdata        <= '0;
         r_cpu_run      <= BOOT_RUN;
         r_done         <= 1'b0;
         r_err_overflow <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_we    <= w_write;
         r_done  <= (w_next_state == ST_DONE) && (r_state != ST_DONE);
         if (w_write) begin
            r_waddr <= {{(32-CNT_W-2){1'b0}}, w_cnt_eff, 2'b00};
            r_wdata <= w_instr;
         end
         if (w_start_ok) begin
            r_count        <= '0;
            r_err_overflow <= 1'b0;
            r_cpu_run      <= 1'b0;
         end else begin
            if (r_we) begin
               r_count <= r_count + CNT_W'(1);
            end
            if (w_overflow) begin
               r_err_overflow <= 1'b1;
            end
            if (w_next_state == ST_DONE) begin
               r_cpu_run <= 1'b1;
            end else if (w_next_state == ST_ERR) begin
               r_cpu_run <= 1'b0;
            end
         end
      end
   end

`ifdef LOADER_CHECKSUM_EN
   // The XOR absorbs each word in its write cycle, so it is complete by the time CHECK is entered.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_xor        <= '0;
         r_err_chksum <= 1'b0;
      end else if (w_start_ok) begin
         r_xor        <= '0;
         r_err_chksum <= 1'b0;
      end else begin
         if (r_we) begin
            r_xor <= r_xor ^ r_wdata;
         end
         if ((r_state == ST_CHECK) && i_chk_valid && !w_chk_match) begin
            r_err_chksum <= 1'b1;
         end
      end
   end

   assign o_err_chksum = r_err_chksum;
`endif

   assign o_fld_ready    = (r_state == ST_LOAD);
   assign o_busy         = (r_state == ST_LOAD) || (r_state == ST_DRAIN) || (r_state == ST_CHECK);
   assign o_imem_we      = r_we;
   assign o_imem_waddr   = r_waddr;
   assign o_imem_wdata   = r_wdata;
   assign o_cpu_run      = r_cpu_run;
   assign o_done         = r_done;
   assign o_err_overflow = r_err_overflow;
   assign o_word_count   = r_count;

endmodule
